// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: queues predictor updates and sequences mispredict recovery.
// Optional BRANCH_STATS_EN adds resolved / mispredict event counters.
module branch_resolve_ctrl #(
    parameter int unsigned VLEN         = 39,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            res_valid_i,
    output logic            res_ready_o,
    input  logic [VLEN-1:0] res_pc_i,
    input  logic [VLEN-1:0] res_target_i,
    input  logic            res_taken_i,
    input  logic            res_mispredict_i,
    input  logic [2:0]      res_cf_i,

    output logic            upd_valid_o,
    input  logic            upd_ready_i,
    output logic [VLEN-1:0] upd_pc_o,
    output logic [VLEN-1:0] upd_target_o,
    output logic            upd_taken_o,
    output logic [2:0]      upd_cf_o,

    output logic            redirect_valid_o,
    output logic [VLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    input  logic            flush_ack_i,

    output logic            busy_o,
    output logic [31:0]     resolved_cnt_o,
    output logic [31:0]     mispredict_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target;
        logic            taken;
        logic [2:0]      cf;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    entry_t           mem [DEPTH];
    entry_t           entry_in;
    entry_t           head_n;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic [FC_W-1:0]  flush_cnt;
    logic [FC_W-1:0]  flush_cnt_inc;
    logic             ack_seen;
    logic             accept;
    logic             pop;
    logic             enter_redirect;
    logic             flush_exit;

    assign entry_in = '{pc: res_pc_i, target: res_target_i, taken: res_taken_i, cf: res_cf_i};

    // Handshakes, recovery exit condition and next queue/FSM values.
    always_comb begin
        accept         = res_valid_i && res_ready_o;
        pop            = upd_valid_o && upd_ready_i;
        enter_redirect = (state == IDLE) && accept && res_mispredict_i;
        flush_cnt_inc  = (flush_cnt >= FC_W'(FLUSH_CYCLES)) ? flush_cnt : flush_cnt + FC_W'(1);
        flush_exit     = (state == FLUSH) && (flush_cnt_inc >= FC_W'(FLUSH_CYCLES))
                         && (ack_seen || flush_ack_i);

        state_n = state;
        case (state)
            IDLE:     if (enter_redirect) state_n = REDIRECT;
            REDIRECT: state_n = FLUSH;
            FLUSH:    if (flush_exit) state_n = IDLE;
            default:  state_n = IDLE;
        endcase

        count_n = count;
        case ({accept, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase

        rd_ptr_n = rd_ptr + PTR_W'(pop);
        // A push into the slot that becomes the head must be forwarded to the registered head.
        head_n   = (accept && (wr_ptr == rd_ptr_n)) ? entry_in : mem[rd_ptr_n];
    end

    // Queue storage needs no reset: occupancy is tracked by count.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    // FSM, queue pointers and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            flush_cnt        <= '0;
            ack_seen         <= 1'b0;
            res_ready_o      <= 1'b0;
            upd_valid_o      <= 1'b0;
            upd_pc_o         <= '0;
            upd_target_o     <= '0;
            upd_taken_o      <= 1'b0;
            upd_cf_o         <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            flush_o          <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            state  <= state_n;
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            case (state)
                REDIRECT: begin
                    flush_cnt <= FC_W'(1);
                    ack_seen  <= ack_seen || flush_ack_i;
                end
                FLUSH: begin
                    if (flush_exit) begin
                        flush_cnt <= '0;
                        ack_seen  <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt_inc;
                        ack_seen  <= ack_seen || flush_ack_i;
                    end
                end
                default: begin
                    flush_cnt <= '0;
                    ack_seen  <= 1'b0;
                end
            endcase

            if (enter_redirect) begin
                redirect_pc_o <= res_target_i;
            end

            res_ready_o      <= (state_n == IDLE) && (count_n != CNT_W'(DEPTH));
            upd_valid_o      <= (count_n != '0);
            upd_pc_o         <= head_n.pc;
            upd_target_o     <= head_n.target;
            upd_taken_o      <= head_n.taken;
            upd_cf_o         <= head_n.cf;
            redirect_valid_o <= (state_n == REDIRECT);
            flush_o          <= (state_n != IDLE);
            busy_o           <= (state_n != IDLE) || (count_n != '0);
        end
    end

`ifdef BRANCH_STATS_EN
    // Wrapping event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resolved_cnt_o   <= '0;
            mispredict_cnt_o <= '0;
        end else if (accept) begin
            resolved_cnt_o <= resolved_cnt_o + 32'd1;
            if (res_mispredict_i) begin
                mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
            end
        end
    end
`else
    assign resolved_cnt_o   = '0;
    assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed table, corner sequences, random vs model.
module tb_branch_resolve_ctrl;

    localparam int unsigned VLEN         = 39;
    localparam int unsigned DEPTH        = 4;
    localparam int unsigned FLUSH_CYCLES = 2;
    // Recovery keeps flush high for the redirect cycle plus at least one flush cycle.
    localparam int          MIN_FLUSH    = (FLUSH_CYCLES > 2) ? FLUSH_CYCLES : 2;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            res_valid_i = 1'b0;
    logic            res_ready_o;
    logic [VLEN-1:0] res_pc_i = '0;
    logic [VLEN-1:0] res_target_i = '0;
    logic            res_taken_i = 1'b0;
    logic            res_mispredict_i = 1'b0;
    logic [2:0]      res_cf_i = '0;
    logic            upd_valid_o;
    logic            upd_ready_i = 1'b0;
    logic [VLEN-1:0] upd_pc_o;
    logic [VLEN-1:0] upd_target_o;
    logic            upd_taken_o;
    logic [2:0]      upd_cf_o;
    logic            redirect_valid_o;
    logic [VLEN-1:0] redirect_pc_o;
    logic            flush_o;
    logic            flush_ack_i = 1'b0;
    logic            busy_o;
    logic [31:0]     resolved_cnt_o;
    logic [31:0]     mispredict_cnt_o;

    always #5 clk_i = ~clk_i;

    branch_resolve_ctrl #(.VLEN(VLEN), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
        .res_pc_i(res_pc_i), .res_target_i(res_target_i), .res_taken_i(res_taken_i),
        .res_mispredict_i(res_mispredict_i), .res_cf_i(res_cf_i),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
        .upd_pc_o(upd_pc_o), .upd_target_o(upd_target_o), .upd_taken_o(upd_taken_o),
        .upd_cf_o(upd_cf_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .flush_o(flush_o), .flush_ack_i(flush_ack_i),
        .busy_o(busy_o), .resolved_cnt_o(resolved_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
    );

    typedef struct {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target;
        logic            taken;
        logic [2:0]      cf;
    } rec_t;

    typedef struct {
        bit              rst, vld, mis, urdy, ack;
        logic [VLEN-1:0] pc, tgt;
        bit              e_rdy, e_uv;
        logic [VLEN-1:0] e_upc;
        bit              e_rv;
        logic [VLEN-1:0] e_rpc;
        bit              e_fl, e_busy;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference: FIFO of records plus recovery age/ack tracking.
    rec_t            q[$];
    bit              m_rst = 1'b1;
    bit              m_rec = 1'b0;
    bit              m_ack = 1'b0;
    int              m_age = 0;
    logic [VLEN-1:0] m_rpc = '0;
    int unsigned     m_res = 0;
    int unsigned     m_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit e_ready();
        return !m_rst && !m_rec && (q.size() < DEPTH);
    endfunction

    function automatic bit e_uvalid();
        return !m_rst && (q.size() != 0);
    endfunction

    task automatic model_step(input bit rst, input bit vld, input bit mis, input rec_t r,
                              input bit urdy, input bit ack);
        bit rdy, uv, acc, pop, got;
        rdy = e_ready();
        uv  = e_uvalid();
        if (rst) begin
            q.delete();
            m_rec = 1'b0; m_ack = 1'b0; m_age = 0; m_rpc = '0;
            m_res = 0; m_mis = 0; m_rst = 1'b1;
            return;
        end
        acc = vld && rdy;
        pop = uv && urdy;
        if (m_rec) begin
            got = m_ack || ack;
            if (m_age >= MIN_FLUSH && got) begin
                m_rec = 1'b0;
            end else begin
                m_age++;
                m_ack = got;
            end
        end else if (acc && mis) begin
            m_rec = 1'b1; m_age = 1; m_ack = 1'b0; m_rpc = r.target;
        end
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(r);
            m_res++;
            if (mis) m_mis++;
        end
        m_rst = 1'b0;
    endtask

    task automatic check_model();
        bit rv;
        rv = !m_rst && m_rec && (m_age == 1);
        chk("res_ready", 64'(res_ready_o), 64'(e_ready()));
        chk("upd_valid", 64'(upd_valid_o), 64'(e_uvalid()));
        if (e_uvalid()) begin
            chk("upd_pc", 64'(upd_pc_o), 64'(q[0].pc));
            chk("upd_target", 64'(upd_target_o), 64'(q[0].target));
            chk("upd_taken", 64'(upd_taken_o), 64'(q[0].taken));
            chk("upd_cf", 64'(upd_cf_o), 64'(q[0].cf));
        end
        if (m_rst) begin
            chk("rst_upd_pc", 64'(upd_pc_o), 64'(0));
            chk("rst_redirect_pc", 64'(redirect_pc_o), 64'(0));
        end
        chk("redirect_valid", 64'(redirect_valid_o), 64'(rv));
        if (rv) chk("redirect_pc", 64'(redirect_pc_o), 64'(m_rpc));
        chk("flush", 64'(flush_o), 64'(!m_rst && m_rec));
        chk("busy", 64'(busy_o), 64'(!m_rst && (m_rec || q.size() != 0)));
`ifdef BRANCH_STATS_EN
        chk("resolved_cnt", 64'(resolved_cnt_o), 64'(m_res));
        chk("mispredict_cnt", 64'(mispredict_cnt_o), 64'(m_mis));
`else
        chk("resolved_cnt", 64'(resolved_cnt_o), 64'(0));
        chk("mispredict_cnt", 64'(mispredict_cnt_o), 64'(0));
`endif
    endtask

    // One clock: inputs already driven, advance model and DUT, then check.
    task automatic tick();
        rec_t r;
        bit   rst, vld, mis, urdy, ack;
        r.pc = res_pc_i; r.target = res_target_i; r.taken = res_taken_i; r.cf = res_cf_i;
        rst = rst_i; vld = res_valid_i; mis = res_mispredict_i;
        urdy = upd_ready_i; ack = flush_ack_i;
        @(posedge clk_i);
        model_step(rst, vld, mis, r, urdy, ack);
        #1;
        check_model();
    endtask

    function automatic vec_t mk(input bit rst, input bit vld, input bit mis, input bit urdy,
                                input bit ack, input logic [VLEN-1:0] pc,
                                input logic [VLEN-1:0] tgt, input bit e_rdy, input bit e_uv,
                                input logic [VLEN-1:0] e_upc, input bit e_rv,
                                input logic [VLEN-1:0] e_rpc, input bit e_fl, input bit e_busy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.mis = mis; v.urdy = urdy; v.ack = ack;
        v.pc = pc; v.tgt = tgt; v.e_rdy = e_rdy; v.e_uv = e_uv; v.e_upc = e_upc;
        v.e_rv = e_rv; v.e_rpc = e_rpc; v.e_fl = e_fl; v.e_busy = e_busy;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        int          waited;
        logic [63:0] rnd;
        // Rows: inputs for one cycle, then outputs expected after that edge.
        tbl[0]  = mk(1,0,0,0,0, 'h0,    'h0,    0,0,'h0,    0,'h0,    0,0);
        tbl[1]  = mk(1,0,0,0,0, 'h0,    'h0,    0,0,'h0,    0,'h0,    0,0);
        tbl[2]  = mk(1,0,0,0,0, 'h0,    'h0,    0,0,'h0,    0,'h0,    0,0);
        tbl[3]  = mk(0,0,0,0,0, 'h0,    'h0,    1,0,'h0,    0,'h0,    0,0);
        tbl[4]  = mk(0,1,0,0,0, 'h1000, 'h2000, 1,1,'h1000, 0,'h0,    0,1);
        tbl[5]  = mk(0,1,0,0,0, 'h1004, 'h2000, 1,1,'h1000, 0,'h0,    0,1);
        tbl[6]  = mk(0,1,0,0,0, 'h1008, 'h2000, 1,1,'h1000, 0,'h0,    0,1);
        tbl[7]  = mk(0,1,0,0,0, 'h100C, 'h2000, 0,1,'h1000, 0,'h0,    0,1);
        tbl[8]  = mk(0,1,0,1,0, 'h1010, 'h2000, 1,1,'h1004, 0,'h0,    0,1);
        tbl[9]  = mk(0,0,0,1,0, 'h0,    'h0,    1,1,'h1008, 0,'h0,    0,1);
        tbl[10] = mk(0,0,0,1,0, 'h0,    'h0,    1,1,'h100C, 0,'h0,    0,1);
        tbl[11] = mk(0,0,0,1,0, 'h0,    'h0,    1,0,'h0,    0,'h0,    0,0);
        tbl[12] = mk(0,1,1,1,0, 'h3000, 'h8040, 0,1,'h3000, 1,'h8040, 1,1);
        tbl[13] = mk(0,0,0,1,1, 'h0,    'h0,    0,0,'h0,    0,'h0,    1,1);
        tbl[14] = mk(0,0,0,1,0, 'h0,    'h0,    1,0,'h0,    0,'h0,    0,0);

        res_taken_i = 1'b1;
        res_cf_i    = 3'd1;
        for (int i = 0; i < 15; i++) begin
            rst_i = tbl[i].rst; res_valid_i = tbl[i].vld; res_mispredict_i = tbl[i].mis;
            upd_ready_i = tbl[i].urdy; flush_ack_i = tbl[i].ack;
            res_pc_i = tbl[i].pc; res_target_i = tbl[i].tgt;
            tick();
            chk($sformatf("tbl%0d_ready", i), 64'(res_ready_o), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_upd_valid", i), 64'(upd_valid_o), 64'(tbl[i].e_uv));
            if (tbl[i].e_uv) chk($sformatf("tbl%0d_upd_pc", i), 64'(upd_pc_o), 64'(tbl[i].e_upc));
            chk($sformatf("tbl%0d_redirect_valid", i), 64'(redirect_valid_o), 64'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_redirect_pc", i), 64'(redirect_pc_o), 64'(tbl[i].e_rpc));
            chk($sformatf("tbl%0d_flush", i), 64'(flush_o), 64'(tbl[i].e_fl));
            chk($sformatf("tbl%0d_busy", i), 64'(busy_o), 64'(tbl[i].e_busy));
        end

        // Ack withheld for 10 cycles while a queued update drains.
        rst_i = 1'b0; upd_ready_i = 1'b0; flush_ack_i = 1'b0;
        res_valid_i = 1'b1; res_mispredict_i = 1'b1;
        res_pc_i = VLEN'(64'h4000); res_target_i = VLEN'(64'h9000);
        tick();
        chk("wait_redirect_valid", 64'(redirect_valid_o), 64'(1));
        chk("wait_redirect_pc", 64'(redirect_pc_o), 64'h9000);
        res_valid_i = 1'b0; res_mispredict_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            upd_ready_i = (i == 3);
            tick();
            chk("wait_flush", 64'(flush_o), 64'(1));
            chk("wait_ready", 64'(res_ready_o), 64'(0));
            chk("wait_upd_valid", 64'(upd_valid_o), 64'(i < 3));
        end
        upd_ready_i = 1'b0; flush_ack_i = 1'b1;
        tick();
        flush_ack_i = 1'b0;
        chk("wait_exit_flush", 64'(flush_o), 64'(0));
        chk("wait_exit_ready", 64'(res_ready_o), 64'(1));

        // Reset during FLUSH with two queued entries abandons everything.
        res_valid_i = 1'b1; res_mispredict_i = 1'b0;
        res_pc_i = VLEN'(64'h5000); res_target_i = VLEN'(64'h5004);
        tick();
        res_mispredict_i = 1'b1; res_pc_i = VLEN'(64'h5004); res_target_i = VLEN'(64'hA000);
        tick();
        res_valid_i = 1'b0; res_mispredict_i = 1'b0;
        tick();
        chk("pre_rst_flush", 64'(flush_o), 64'(1));
        rst_i = 1'b1;
        tick();
        chk("rst_flush", 64'(flush_o), 64'(0));
        chk("rst_upd_valid", 64'(upd_valid_o), 64'(0));
        chk("rst_redirect", 64'(redirect_valid_o), 64'(0));
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_redirect", 64'(redirect_valid_o), 64'(0));
            chk("post_rst_busy", 64'(busy_o), 64'(0));
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst_i            = ($urandom_range(0, 199) == 0);
            res_valid_i      = ($urandom_range(0, 9) < 6);
            res_mispredict_i = ($urandom_range(0, 99) < 15);
            rnd              = {$urandom(), $urandom()};
            res_pc_i         = VLEN'(rnd);
            rnd              = {$urandom(), $urandom()};
            res_target_i     = VLEN'(rnd);
            res_taken_i      = 1'($urandom_range(0, 1));
            res_cf_i         = 3'($urandom_range(0, 4));
            upd_ready_i      = ((c / 500) % 2 == 1) ? ($urandom_range(0, 9) < 8)
                                                    : ($urandom_range(0, 9) < 3);
            flush_ack_i      = ($urandom_range(0, 4) == 0);
            tick();
        end

        // Counter check: 5 accepted records, 2 of them mispredicts.
        rst_i = 1'b1; res_valid_i = 1'b0; res_mispredict_i = 1'b0;
        upd_ready_i = 1'b1; flush_ack_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            waited = 0;
            while (!e_ready() && waited < 20) begin
                tick();
                waited++;
            end
            chk("stats_wait_ready", 64'(waited < 20), 64'(1));
            res_valid_i = 1'b1; res_mispredict_i = (k == 1 || k == 3);
            res_pc_i = VLEN'(64'h6000 + 64'(4 * k)); res_target_i = VLEN'(64'h7000);
            tick();
            res_valid_i = 1'b0; res_mispredict_i = 1'b0;
        end
        for (int i = 0; i < 6; i++) tick();
`ifdef BRANCH_STATS_EN
        chk("final_resolved", 64'(resolved_cnt_o), 64'(5));
        chk("final_mispredict", 64'(mispredict_cnt_o), 64'(2));
`else
        chk("final_resolved", 64'(resolved_cnt_o), 64'(0));
        chk("final_mispredict", 64'(mispredict_cnt_o), 64'(0));
`endif
        chk("final_busy", 64'(busy_o), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sits between the execute-stage branch unit and the frontend. It accepts resolved-branch records and queues them as predictor-update requests to the BTB/BHT/RAS through a valid/ready handshake. On a mispredict it sequences the recovery: one-cycle PC redirect, a held frontend flush, and completion on the frontend acknowledge. It backpressures the branch unit while recovery is in progress or the queue is full.

Parameters:
VLEN, 39, virtual address / PC width
DEPTH, 4, update-queue entries; power of 2, >= 2
FLUSH_CYCLES, 2, minimum cycles flush_o stays high; >= 1

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
res_valid_i  input  1  resolved branch record valid
res_ready_o  output  1  controller can accept a record
res_pc_i  input  VLEN  PC of the resolved branch
res_target_i  input  VLEN  correct next PC (taken target or pc+4)
res_taken_i  input  1  branch resolved taken
res_mispredict_i  input  1  prediction was wrong
res_cf_i  input  3  control-flow type (NoCF/Branch/Jump/JumpR/Return encoding)
upd_valid_o  output  1  predictor update request valid
upd_ready_i  input  1  predictor accepts update
upd_pc_o  output  VLEN  update PC
upd_target_o  output  VLEN  update target
upd_taken_o  output  1  update taken bit
upd_cf_o  output  3  update cf type
redirect_valid_o  output  1  frontend PC redirect strobe
redirect_pc_o  output  VLEN  redirect address
flush_o  output  1  flush frontend and un-issued instructions
flush_ack_i  input  1  frontend reports flush complete
busy_o  output  1  FSM not IDLE or queue not empty
resolved_cnt_o  output  32  resolved-branch count (optional feature)
mispredict_cnt_o  output  32  mispredict count (optional feature)

Behaviour:
- Reset (rst_i high at a clk_i edge): FSM=IDLE; queue empty; flush counter=0; ack latch=0. All outputs 0, including res_ready_o, for the reset cycle. res_ready_o is 1 in the first cycle after reset release.
- Reset mid-recovery abandons the recovery: no further redirect or flush, queue contents discarded.
- Accept: a record is accepted when res_valid_i && res_ready_o. res_ready_o = (state==IDLE) && !full. There is no bypass: when full, res_ready_o stays 0 even if a dequeue occurs in the same cycle.
- Every accepted record is enqueued as {pc, target, taken, cf}, including NoCF records.
- Queue: registered FIFO with read/write pointers of log2(DEPTH) bits that wrap naturally, plus a count register.
  - upd_valid_o = !empty; upd_* = head entry; pop on upd_valid_o && upd_ready_i.
  - Accept in cycle N gives upd_valid_o in cycle N+1 at the earliest.
  - Simultaneous push and pop keeps the count unchanged. Order is strictly FIFO.
  - The queue keeps draining in every FSM state.
- FSM:
  - IDLE: an accepted record with res_mispredict_i=1 latches res_target_i into redirect_pc_o and moves to REDIRECT.
  - REDIRECT (exactly 1 cycle): redirect_valid_o=1, flush_o=1, res_ready_o=0, flush counter loads 1. Next state FLUSH.
  - FLUSH: flush_o=1, counter increments and saturates at FLUSH_CYCLES. flush_ack_i is sampled and latched in every cycle of REDIRECT and FLUSH. Exit to IDLE at the edge where counter >= FLUSH_CYCLES and the ack is latched (or flush_ack_i is high). Clear the latch on exit.
  - With FLUSH_CYCLES=1, an ack in REDIRECT is recorded and FLUSH lasts 1 cycle.
- flush_ack_i outside REDIRECT/FLUSH is ignored.
- redirect_pc_o holds its value until the next mispredict; it is meaningful only while redirect_valid_o=1.
- busy_o = (state!=IDLE) || !empty.

Optional Feature:
BRANCH_STATS_EN
- Defined: 32-bit counters, cleared by reset, wrap at 2^32.
  - resolved_cnt_o increments on each accepted record.
  - mispredict_cnt_o increments on each accepted record with res_mispredict_i=1.
- Undefined: both ports remain present and are driven constant 0; no counter flops.

Test Plan:
- Reset with rst_i=1 for 3 cycles, then release -> all outputs 0 during reset; res_ready_o=1 the cycle after release; busy_o=0.
- 4 correctly predicted records (pc 0x1000..0x100C, target 0x2000) with upd_ready_i=0 -> res_ready_o=0 after the 4th; set upd_ready_i=1 -> 4 updates emitted in order, one per cycle; res_ready_o=1 after the first pop.
- Mispredict record with target 0x8040 accepted in cycle N, FLUSH_CYCLES=2, flush_ack_i pulsed at N+1 -> redirect_valid_o=1 only at N+1 with redirect_pc_o=0x8040; flush_o high N+1..N+2; IDLE and res_ready_o=1 at N+3.
- Mispredict with flush_ack_i withheld for 10 cycles -> flush_o stays 1 and res_ready_o stays 0 for the whole wait; queued updates still drain; exit the cycle after ack.
- rst_i asserted during FLUSH with 2 queued entries -> next cycle flush_o=0, upd_valid_o=0, state IDLE, no redirect.
- BRANCH_STATS_EN defined, 5 records accepted of which 2 are mispredicts -> resolved_cnt_o=5, mispredict_cnt_o=2. Undefined -> both read 0.
